seg_scan_ctrl: RTL

Time-multiplexing controller for the 8-digit seven-segment display path. Holds one 4-bit value per digit in an internal register bank and cycles through the digits. For each digit it drives the structural decoder's data inputs (a,b,c,d) and digit-select inputs (s1,s2,s3). It inserts a blanking interval at each digit change to prevent ghosting. It sits between the system's write side and the existing combinational decoder/anode logic.

---
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Holds the digit bank, steps the digit index, and drives decoder inputs with per-slot blanking.
module seg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_mask,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       blank,
  output logic       frame_tick
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mask_q, mask_d;
  logic [3:0]       bank_q [8];
  logic [3:0]       bank_d [8];

  logic [3:0]       data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Outputs are registered from the next-state values, so they change on the
  // same edge as the state they describe and carry no input-to-output path.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    wrap    = 1'b0;

    if (wr_en) bank_d[wr_addr] = wr_data;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SCAN;
          idx_d   = 3'd0;
          cnt_d   = '0;
          mask_d  = digit_mask;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            wrap   = 1'b1;
            mask_d = digit_mask;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    data_d  = 4'd0;
    sel_d   = 3'd0;
    blank_d = 1'b1;
    tick_d  = 1'b0;
    if (state_d == SCAN) begin
      sel_d   = idx_d;
      data_d  = bank_d[idx_d];
      blank_d = (cnt_d < BLANK_END) | ~mask_d[idx_d];
      tick_d  = wrap;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      mask_q  <= 8'hFF;
      // NOTE: the bank is reset on purpose because reads must return zero after
      // reset; this keeps it as flops rather than RAM, acceptable at 8x4 bits.
      for (int i = 0; i < 8; i++) bank_q[i] <= 4'd0;
      data_q  <= 4'd0;
      sel_q   <= 3'd0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      for (int i = 0; i < 8; i++) bank_q[i] <= bank_d[i];
      data_q  <= data_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  assign {a, b, c, d}  = data_q;
  assign {s1, s2, s3}  = sel_q;
  assign blank         = blank_q;
  assign frame_tick    = tick_q;

endmodule
